// File: rtl/counter_pkg.sv
// Shared types for the counter monitor: FSM state encoding and the default counter width.
// The width constant is also used by the upstream counter module.
package counter_pkg;

  localparam int unsigned CNT_WIDTH = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating fault counter: counts increments, holds at all-ones, clear beats increment.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [ERR_W-1:0] o_count
);

  logic [ERR_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {ERR_W{1'b1}})) begin
      r_count <= r_count + ERR_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_monitor.sv
// Checks that an upstream counter increments by one each cycle; locks after LOCK_CNT good steps.
// Outputs update one edge after the sample. Macro COUNTER_MONITOR_CAPTURE_EN builds the last_bad register.
module counter_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_count,
  output logic [WIDTH-1:0] o_last_bad
);

  localparam int RUN_W = 4;

  mon_state_t       r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_valid;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic             r_err_pulse;

  logic             w_good;
  logic             w_fault;
  logic [RUN_W-1:0] w_run_inc;

  // Modular add gives the all-ones -> zero wrap for free.
  assign w_good    = (i_data == (r_prev + WIDTH'(1)));
  assign w_fault   = i_en && (r_state == LOCKED) && !w_good;
  assign w_run_inc = r_run + RUN_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (!i_en) begin
        r_state      <= IDLE;
        r_prev_valid <= 1'b0;
        r_run        <= '0;
        r_locked     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= SYNC;
          end
          SYNC: begin
            r_prev       <= i_data;
            r_prev_valid <= 1'b1;
            if (r_prev_valid) begin
              if (!w_good) begin
                r_run <= '0;
              end else if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_run    <= '0;
              end else begin
                r_run <= w_run_inc;
              end
            end
          end
          LOCKED: begin
            r_prev <= i_data;
            if (!w_good) begin
              r_err_pulse <= 1'b1;
              r_state     <= SYNC;
              r_locked    <= 1'b0;
              r_run       <= '0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_fault),
    .i_clear (i_clear),
    .o_count (o_err_count)
  );

`ifdef COUNTER_MONITOR_CAPTURE_EN
  logic [WIDTH-1:0] r_last_bad;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_last_bad <= '0;
    end else if (w_fault) begin
      r_last_bad <= i_data;
    end
  end

  assign o_last_bad = r_last_bad;
`else
  assign o_last_bad = '0;
`endif

  assign o_locked    = r_locked;
  assign o_err_pulse = r_err_pulse;

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter WIDTH, default 26: width of the monitored counter value.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 Parameter LOCK_CNT, default 4: consecutive good increments required to lock; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data  input  WIDTH  counter value from the upstream counter module, sampled every rising clk edge.
REQ-007 en  input  1  monitor enable; 0 forces the monitor to IDLE.
REQ-008 clear  input  1  synchronous clear of err_count and last_bad.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 err_pulse  output  1  one-cycle pulse per detected increment fault.
REQ-011 err_count  output  ERR_W  saturating count of faults.
REQ-012 last_bad  output  WIDTH  data value of the most recent faulting sample.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SYNC, LOCKED.
REQ-014 A sample is "good" when data == (prev + 1) mod 2^WIDTH; prev is the data registered on the previous edge; all-ones to zero SHALL be good.
REQ-015 IDLE: prev_valid=0, run=0; en=1 -> SYNC on next edge.
REQ-016 SYNC: the first sample after entry only loads prev, with no comparison; later good samples increment run; a bad sample resets run to 0 without err_pulse.
REQ-017 SYNC -> LOCKED on the edge where the LOCK_CNT-th consecutive good sample is registered; locked=1 from that edge.
REQ-018 LOCKED: a bad sample -> err_pulse=1 for exactly the following cycle, err_count+1 (saturating at all-ones), last_bad=data, state -> SYNC with run=0 and prev=data (prev_valid stays 1).
REQ-019 Latency: sample at edge N; locked/err_pulse/err_count/last_bad SHALL reflect it after edge N, visible in cycle N..N+1.
REQ-020 en=0 in any state -> IDLE on the next edge; locked=0; err_count and last_bad held.
REQ-021 clear=1 sets err_count=0 and last_bad=0; clear has priority over a simultaneous fault increment, but err_pulse still fires.
REQ-022 err_count SHALL NOT wrap; at 2^ERR_W-1 further faults leave it unchanged and still pulse err_pulse.
REQ-023 prev SHALL update every edge while en=1, in every non-IDLE state.

Reset
REQ-024 rst=1 SHALL, on the next edge and with priority over en/clear: state=IDLE, prev=0, prev_valid=0, run=0, locked=0, err_pulse=0, err_count=0, last_bad=0.
REQ-025 Reset asserted mid-LOCKED SHALL abort without err_pulse; relock requires full SYNC.

Configuration
REQ-026 Macro COUNTER_MONITOR_CAPTURE_EN: defined -> last_bad register built and updated per REQ-018/021; undefined -> no register, last_bad tied to 0, all other behaviour identical.

Structure
REQ-027 Package counter_pkg SHALL hold the FSM state enum (IDLE, SYNC, LOCKED) and the default width constant 26 shared with the counter module.
REQ-028 Sub-module sat_counter (parameter ERR_W; inputs inc, clear; output count) SHALL implement err_count.

Verification
REQ-029 Reset, en=1, data=0,1,2,...: locked rises after the edge sampling data=4 (LOCK_CNT=4), err_count=0 throughout.
REQ-030 Locked, data sequence 10,11,13: err_pulse high exactly one cycle, err_count=1, last_bad=13, locked=0; relock after 14,15,16,17.
REQ-031 Locked, data 0x3FFFFFE,0x3FFFFFF,0x0000000: no error, locked stays 1.
REQ-032 ERR_W=2, force 5 faults with relocks in between: err_count = 3, 3, 3 after third, fourth, fifth fault; five err_pulses seen.
REQ-033 clear=1 on the same edge as a fault: err_pulse=1, err_count=0, last_bad=0.
REQ-034 rst pulsed while locked with err_count=2: all outputs 0 next cycle; without COUNTER_MONITOR_CAPTURE_EN, last_bad=0 in every scenario.
